// File: rtl/div_mon.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module   : div_mon
// Purpose  : Measures the period of an asynchronous divided clock and reports
//            lock / fault status against an expected period and tolerance.
// Revision : 1.0 - initial release
//==============================================================================
module div_mon #(
   parameter int CW         = 8,
   parameter int EXP_PERIOD = 16,
   parameter int TOL        = 1,
   parameter int LOCK_CNT   = 4
) (
   input  logic          ip1,
   input  logic          reset,
   input  logic          div_in,
   input  logic          clr_fault,
   output logic          rise_pulse,
   output logic [CW-1:0] period,
   output logic          period_vld,
   output logic          locked,
   output logic          fault
);

   localparam int GW = $clog2(LOCK_CNT + 1);

   localparam logic [1:0] c_IDLE    = 2'd0;
   localparam logic [1:0] c_ACQUIRE = 2'd1;
   localparam logic [1:0] c_LOCKED  = 2'd2;
   localparam logic [1:0] c_FAULT   = 2'd3;

   localparam logic [CW-1:0] c_CNT_MAX = {CW{1'b1}};
   localparam logic [CW-1:0] c_PER_LO  = CW'(EXP_PERIOD - TOL);
   localparam logic [CW-1:0] c_PER_HI  = CW'(EXP_PERIOD + TOL);
   localparam logic [GW-1:0] c_LOCK_N  = GW'(LOCK_CNT);

   logic          r_s1, r_s2, r_s3;
   logic [CW-1:0] r_cnt;
   logic [1:0]    r_state;
   logic [GW-1:0] r_gcnt;

   logic          w_edge;
   logic          w_good;
   logic          w_timeout;
   logic [CW-1:0] w_cnt_inc;
   logic [GW-1:0] w_gcnt_inc;
   logic [1:0]    w_state_nxt;
   logic [GW-1:0] w_gcnt_nxt;
   logic          w_vld;

   assign w_edge     = r_s2 & ~r_s3;
   assign w_cnt_inc  = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + CW'(1);
   assign w_good     = (r_cnt >= c_PER_LO) && (r_cnt <= c_PER_HI);
   assign w_timeout  = ~w_edge && (r_cnt == c_CNT_MAX);
   assign w_gcnt_inc = r_gcnt + GW'(1);

   always_comb begin
      w_state_nxt = r_state;
      w_gcnt_nxt  = r_gcnt;
      w_vld       = 1'b0;
      case (r_state)
         c_IDLE: begin
            if (w_edge) begin
               w_state_nxt = c_ACQUIRE;
               w_gcnt_nxt  = '0;
            end
         end
         c_ACQUIRE: begin
            if (w_edge) begin
               w_vld = 1'b1;
               if (w_good) begin
                  w_gcnt_nxt = w_gcnt_inc;
                  if (w_gcnt_inc == c_LOCK_N)
                     w_state_nxt = c_LOCKED;
               end else begin
                  w_gcnt_nxt = '0;
               end
            end else if (w_timeout) begin
               w_state_nxt = c_IDLE;
               w_gcnt_nxt  = '0;
            end
         end
         c_LOCKED: begin
            if (w_edge) begin
               w_vld = 1'b1;
               if (!w_good)
                  w_state_nxt = c_FAULT;
            end else if (w_timeout) begin
               w_state_nxt = c_FAULT;
            end
         end
         c_FAULT: begin
            // clear beats a coincident edge; that edge is neither measured nor acted on
            if (clr_fault) begin
               w_state_nxt = c_IDLE;
               w_gcnt_nxt  = '0;
            end else if (w_edge) begin
               w_vld = 1'b1;
            end
         end
         default: begin
            w_state_nxt = c_IDLE;
            w_gcnt_nxt  = '0;
         end
      endcase
   end

   always_ff @(posedge ip1) begin
      if (reset) begin
         r_s1       <= 1'b0;
         r_s2       <= 1'b0;
         r_s3       <= 1'b0;
         r_cnt      <= '0;
         r_state    <= c_IDLE;
         r_gcnt     <= '0;
         rise_pulse <= 1'b0;
         period_vld <= 1'b0;
         period     <= '0;
         locked     <= 1'b0;
         fault      <= 1'b0;
      end else begin
         r_s1       <= div_in;
         r_s2       <= r_s1;
         r_s3       <= r_s2;
         r_cnt      <= w_edge ? CW'(1) : w_cnt_inc;
         r_state    <= w_state_nxt;
         r_gcnt     <= w_gcnt_nxt;
         rise_pulse <= w_edge;
         period_vld <= w_vld;
         if (w_vld)
            period <= r_cnt;
         locked     <= (r_state == c_LOCKED);
         fault      <= (r_state == c_FAULT);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_div_mon.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module   : tb_div_mon
// Purpose  : Self-checking bench for div_mon: directed scenarios plus random
//            periods, compared cycle by cycle against a behavioural model.
// Revision : 1.0 - initial release
//==============================================================================
module tb_div_mon;

   localparam int EXP   = 16;
   localparam int TOLR  = 1;
   localparam int LOCKN = 4;
   localparam int MAXC  = 255;

   logic       ip1 = 1'b0;
   logic       reset;
   logic       div_in;
   logic       clr_fault;
   logic       rise_pulse;
   logic [7:0] period;
   logic       period_vld;
   logic       locked;
   logic       fault;

   div_mon #(.CW(8), .EXP_PERIOD(EXP), .TOL(TOLR), .LOCK_CNT(LOCKN)) dut (
      .ip1        (ip1),
      .reset      (reset),
      .div_in     (div_in),
      .clr_fault  (clr_fault),
      .rise_pulse (rise_pulse),
      .period     (period),
      .period_vld (period_vld),
      .locked     (locked),
      .fault      (fault)
   );

   always #5 ip1 = ~ip1;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Behavioural reference: history of raw div_in samples, elapsed time
   // since the last seen rising edge, and an operating mode.
   typedef enum int {M_IDLE, M_ACQ, M_LOCK, M_FAULT} mode_t;
   mode_t mode = M_IDLE;
   int    good_run = 0;
   int    elapsed  = 0;
   bit    hist[$]  = '{0, 0, 0};
   bit    exp_rise, exp_vld, exp_locked, exp_fault;
   int    exp_period = 0;

   task automatic model_step(input bit d, input bit c, input bit r);
      bit edge_seen, timeout, good;
      int captured;
      if (r) begin
         hist = '{0, 0, 0};
         elapsed = 0; mode = M_IDLE; good_run = 0;
         exp_rise = 0; exp_vld = 0; exp_locked = 0; exp_fault = 0; exp_period = 0;
         return;
      end
      // a rise is seen once the sample two clocks back is 1 and three back is 0
      edge_seen  = hist[1] && !hist[2];
      exp_locked = (mode == M_LOCK);
      exp_fault  = (mode == M_FAULT);
      exp_rise   = edge_seen;
      exp_vld    = 0;
      captured   = elapsed;
      timeout    = !edge_seen && (elapsed == MAXC);
      good       = (captured >= EXP - TOLR) && (captured <= EXP + TOLR);
      case (mode)
         M_IDLE:  if (edge_seen) begin mode = M_ACQ; good_run = 0; end
         M_ACQ: begin
            if (edge_seen) begin
               exp_vld = 1;
               if (good) begin
                  good_run++;
                  if (good_run == LOCKN) mode = M_LOCK;
               end else good_run = 0;
            end else if (timeout) begin
               mode = M_IDLE; good_run = 0;
            end
         end
         M_LOCK: begin
            if (edge_seen) begin
               exp_vld = 1;
               if (!good) mode = M_FAULT;
            end else if (timeout) mode = M_FAULT;
         end
         M_FAULT: begin
            if (c) begin mode = M_IDLE; good_run = 0; end
            else if (edge_seen) exp_vld = 1;
         end
         default: mode = M_IDLE;
      endcase
      if (exp_vld) exp_period = captured;
      elapsed = edge_seen ? 1 : ((elapsed + 1 > MAXC) ? MAXC : elapsed + 1);
      hist.push_front(d);
      void'(hist.pop_back());
   endtask

   int  vld_seen    = 0;
   int  rises_total = 0;
   int  rises       = 0;
   int  last_period = 0;
   bit  arm5        = 0;
   bit  chk5_next   = 0;

   task automatic cycle(input bit d, input bit c, input bit r);
      @(negedge ip1);
      div_in = d; clr_fault = c; reset = r;
      @(posedge ip1);
      model_step(d, c, r);
      #1;
      check("rise_pulse", rise_pulse, exp_rise);
      check("period_vld", period_vld, exp_vld);
      check("period",     period,     exp_period);
      check("locked",     locked,     exp_locked);
      check("fault",      fault,      exp_fault);
      if (chk5_next) begin
         check("locked_after_5th_rise", locked, 1);
         chk5_next = 0;
      end
      if (period_vld) begin
         vld_seen++;
         last_period = period;
      end
      if (rise_pulse) begin
         rises_total++;
         rises++;
         if (arm5 && rises == 5) begin
            check("locked_at_5th_rise", locked, 0);
            chk5_next = 1;
            arm5 = 0;
         end
      end
   endtask

   task automatic wave(input int p, input int h);
      for (int i = 0; i < p; i++) cycle(i < h, 0, 0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rise"},   rise_pulse, 0);
      check({tag, "_vld"},    period_vld, 0);
      check({tag, "_period"}, period,     0);
      check({tag, "_locked"}, locked,     0);
      check({tag, "_fault"},  fault,      0);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int v0, r0, p, h;
      reset = 1'b1; div_in = 1'b0; clr_fault = 1'b0;

      repeat (3) cycle(0, 0, 1);
      check_all_zero("reset");
      r0 = rises_total;
      repeat (20) cycle(0, 0, 0);
      check("idle_no_rise", rises_total - r0, 0);

      arm5 = 1; rises = 0;
      repeat (6) wave(16, 8);
      check("lock16", locked, 1);
      check("per16", last_period, 16);

      wave(17, 8); wave(16, 8);
      check("per17", last_period, 17);
      check("lock17", locked, 1);
      wave(18, 9); wave(16, 8);
      check("per18", last_period, 18);
      check("fault18", fault, 1);
      check("unlock18", locked, 0);

      cycle(0, 1, 0); cycle(0, 0, 0); cycle(0, 0, 0);
      check("clr_fault", fault, 0);
      repeat (6) wave(16, 8);
      check("relock", locked, 1);

      v0 = vld_seen;
      repeat (300) cycle(0, 0, 0);
      check("timeout_fault", fault, 1);
      check("timeout_locked", locked, 0);
      check("timeout_no_vld", vld_seen - v0, 0);

      v0 = vld_seen;
      cycle(1, 0, 0); cycle(1, 0, 0); cycle(1, 1, 0); cycle(1, 0, 0);
      check("clr_edge_fault", fault, 0);
      check("clr_edge_locked", locked, 0);
      check("clr_edge_no_vld", vld_seen - v0, 0);

      repeat (4) cycle(0, 0, 0);
      repeat (6) wave(16, 8);
      check("lock_before_rst", locked, 1);
      cycle(0, 0, 1);
      check_all_zero("midrst");
      arm5 = 1; rises = 0;
      repeat (6) wave(16, 8);
      check("lock_after_rst", locked, 1);

      // reset released while div_in is already high
      cycle(1, 0, 1); cycle(1, 0, 1);
      r0 = rises_total;
      repeat (10) cycle(1, 0, 0);
      check("high_rst_one_rise", rises_total - r0, 1);

      for (int k = 0; k < 60; k++) begin
         p = $urandom_range(14, 18);
         if ($urandom_range(0, 9) == 0) p = $urandom_range(20, 40);
         h = $urandom_range(1, p - 1);
         for (int i = 0; i < p; i++)
            cycle(i < h, $urandom_range(0, 29) == 0, $urandom_range(0, 299) == 0);
         if ($urandom_range(0, 19) == 0)
            repeat (270) cycle(0, $urandom_range(0, 49) == 0, 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
